// File: rtl/phy_test_pkg.sv
// Shared types and defaults for the PHY test datapath.
//   NUM_LANES_DEF / LANE_BITS_DEF : default lane count and serial bits per lane beat
//   deser_state_e                 : deserializer FSM states
//   beat_t                        : one beat, a packed array of NUM_LANES_DEF bytes
package phy_test_pkg;

  localparam int unsigned NUM_LANES_DEF = 16;
  localparam int unsigned LANE_BITS_DEF = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } deser_state_e;

  typedef logic [NUM_LANES_DEF-1:0][7:0] beat_t;

endpackage

// File: rtl/phy_beat_fifo.sv
// Synchronous beat FIFO.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   enq, wrData  : enqueue request and data; accepted when not full, or when full and
//                  a dequeue happens in the same cycle
//   deq          : dequeue request; ignored while empty
//   rdData       : head entry (registered storage, no path from deq)
//   full, empty  : occupancy flags
module phy_beat_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq,
  input  logic [Width-1:0] wrData,
  input  logic             deq,
  output logic [Width-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Depth-1:0][Width-1:0] memQ;
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AddrW:0] wrPtrQ, rdPtrQ;
  logic           doEnq, doDeq;

  assign empty = (wrPtrQ == rdPtrQ);
  assign full  = (wrPtrQ[AddrW] != rdPtrQ[AddrW]) &&
                 (wrPtrQ[AddrW-1:0] == rdPtrQ[AddrW-1:0]);

  assign doDeq = deq && !empty;
  // Full with a same-cycle dequeue frees the head slot in time for the write.
  assign doEnq = enq && (!full || doDeq);

  assign rdData = memQ[rdPtrQ[AddrW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memQ   <= '0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (doEnq) begin
        memQ[wrPtrQ[AddrW-1:0]] <= wrData;
        wrPtrQ                  <= wrPtrQ + (AddrW+1)'(1);
      end
      if (doDeq) begin
        rdPtrQ <= rdPtrQ + (AddrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/phy_lane_deser.sv
// Receive-side lane deserializer: rebuilds one byte per lane every LANE_BITS valid
// serial bits (MSB first), buffers completed beats and presents them ready/valid.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   io_ser_data/valid    : one serial bit per lane, framed by a shared valid lane
//   io_out_valid/ready   : output handshake; io_out_bits holds lane l at [8l+7:8l]
//   io_busy              : a beat is partially assembled
//   io_cnt_clear         : synchronous clear of both error counters
//   io_overflow_cnt      : saturating count of beats dropped on a full FIFO
//   io_frame_err_cnt     : saturating count of partial beats discarded
// Build option: PHY_LANE_DESER_ERR_CNT_EN enables the error counters; when undefined
// they read 0 and io_cnt_clear is ignored (dropping/discarding is unaffected).
module phy_lane_deser
  import phy_test_pkg::*;
#(
  parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
  parameter int unsigned LANE_BITS  = LANE_BITS_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   io_ser_data,
  input  logic                   io_ser_valid,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [NUM_LANES*8-1:0] io_out_bits,
  output logic                   io_busy,
  input  logic                   io_cnt_clear,
  output logic [7:0]             io_overflow_cnt,
  output logic [7:0]             io_frame_err_cnt
);

  localparam int unsigned CntW = $clog2(LANE_BITS);

  deser_state_e                          stateQ, stateD;
  logic [CntW-1:0]                       cntQ, cntD;
  logic [NUM_LANES-1:0][LANE_BITS-2:0]   shiftQ;
  logic [NUM_LANES-1:0][LANE_BITS-1:0]   beatWord;
  logic                                  beatDone;
  logic                                  frameErr;
  logic                                  fifoFull;
  logic                                  fifoEmpty;
  logic                                  outDeq;
  logic                                  overflow;

  // FSM: next state, bit count and the per-cycle completion/discard events.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    beatDone = 1'b0;
    frameErr = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (io_ser_valid) begin
          stateD = SHIFT;
          cntD   = CntW'(1);
        end
      end
      SHIFT: begin
        if (io_ser_valid) begin
          if (cntQ == CntW'(LANE_BITS - 1)) begin
            beatDone = 1'b1;
            cntD     = '0;
            stateD   = IDLE;
          end else begin
            cntD = cntQ + CntW'(1);
          end
        end else begin
          frameErr = 1'b1;
          cntD     = '0;
          stateD   = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Shift registers hold only the first LANE_BITS-1 bits; the last bit goes straight
  // into the FIFO word. Stale bits after a discard are shifted out by the next beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shiftQ <= '0;
    end else if (io_ser_valid) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        shiftQ[l] <= {shiftQ[l][LANE_BITS-3:0], io_ser_data[l]};
      end
    end
  end

  always_comb begin
    beatWord = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      beatWord[l] = {shiftQ[l], io_ser_data[l]};
    end
  end

  assign io_busy      = (cntQ != '0);
  assign io_out_valid = !fifoEmpty;
  assign outDeq       = io_out_valid && io_out_ready;
  assign overflow     = beatDone && fifoFull && !io_out_ready;

  phy_beat_fifo #(
    .Width(NUM_LANES * LANE_BITS),
    .Depth(FIFO_DEPTH)
  ) uFifo (
    .clock (clock),
    .reset (reset),
    .enq   (beatDone),
    .wrData(beatWord),
    .deq   (outDeq),
    .rdData(io_out_bits),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

`ifdef PHY_LANE_DESER_ERR_CNT_EN
  logic [7:0] ovfCntQ, ferrCntQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovfCntQ  <= '0;
      ferrCntQ <= '0;
    end else if (io_cnt_clear) begin
      ovfCntQ  <= '0;
      ferrCntQ <= '0;
    end else begin
      if (overflow && (ovfCntQ != 8'hFF)) begin
        ovfCntQ <= ovfCntQ + 8'd1;
      end
      if (frameErr && (ferrCntQ != 8'hFF)) begin
        ferrCntQ <= ferrCntQ + 8'd1;
      end
    end
  end

  assign io_overflow_cnt  = ovfCntQ;
  assign io_frame_err_cnt = ferrCntQ;
`else
  logic unusedCntInputs;
  assign unusedCntInputs  = ^{io_cnt_clear, overflow, frameErr};
  assign io_overflow_cnt  = '0;
  assign io_frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_phy_lane_deser.sv
module tb_phy_lane_deser;
  import phy_test_pkg::*;

  localparam int NL    = 16;
  localparam int DEPTH = 2;
`ifdef PHY_LANE_DESER_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NL-1:0]   serData = '0;
  logic            serValid = 1'b0;
  logic            outReady = 1'b0;
  logic            cntClear = 1'b0;
  logic            outValid;
  logic [NL*8-1:0] outBits;
  logic            busy;
  logic [7:0]      ovfCnt;
  logic [7:0]      ferrCnt;

  int checks = 0;
  int failures = 0;

  // Reference model: per-lane accumulated value, bit count, beat queue, counters.
  int    mLane[NL];
  int    mCount;
  beat_t mQ[$];
  int    mOvf;
  int    mFerr;

  always #5 clock = ~clock;

  phy_lane_deser dut (
    .clock           (clock),
    .reset           (reset),
    .io_ser_data     (serData),
    .io_ser_valid    (serValid),
    .io_out_valid    (outValid),
    .io_out_ready    (outReady),
    .io_out_bits     (outBits),
    .io_busy         (busy),
    .io_cnt_clear    (cntClear),
    .io_overflow_cnt (ovfCnt),
    .io_frame_err_cnt(ferrCnt)
  );

  task automatic model_reset();
    for (int l = 0; l < NL; l++) mLane[l] = 0;
    mCount = 0;
    mQ.delete();
    mOvf = 0;
    mFerr = 0;
  endtask

  // Apply one cycle of inputs, advance the model, and step past the clock edge.
  task automatic cycle(input logic v, input logic [NL-1:0] d, input logic rdy,
                       input logic clr);
    bit    deq;
    bit    done;
    beat_t w;
    serValid = v;
    serData  = d;
    outReady = rdy;
    cntClear = clr;
    deq  = (mQ.size() > 0) && rdy;
    done = 1'b0;
    w    = '0;
    if (v) begin
      for (int l = 0; l < NL; l++) mLane[l] = mLane[l] * 2 + int'(d[l]);
      mCount++;
      if (mCount == 8) begin
        for (int l = 0; l < NL; l++) begin
          w[l] = 8'(mLane[l]);
          mLane[l] = 0;
        end
        mCount = 0;
        done = 1'b1;
      end
    end else if (mCount != 0) begin
      for (int l = 0; l < NL; l++) mLane[l] = 0;
      mCount = 0;
      if (mFerr < 255) mFerr++;
    end
    if (done && !(mQ.size() < DEPTH || deq)) begin
      done = 1'b0;
      if (mOvf < 255) mOvf++;
    end
    if (clr) begin
      mOvf = 0;
      mFerr = 0;
    end
    if (!CntEn) begin
      mOvf = 0;
      mFerr = 0;
    end
    if (deq) void'(mQ.pop_front());
    if (done) mQ.push_back(w);
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input beat_t b, input logic rdy);
    logic [NL-1:0] d;
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < NL; l++) d[l] = b[l][7-i];
      cycle(1'b1, d, rdy, 1'b0);
    end
  endtask

  function automatic beat_t all_lanes(input logic [7:0] v);
    beat_t b;
    for (int l = 0; l < NL; l++) b[l] = v;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int l = 0; l < NL; l++) b[l] = 8'($urandom);
    return b;
  endfunction

  task automatic test_reset();
    serValid = 1'b0;
    outReady = 1'b0;
    cntClear = 1'b0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (outValid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b expected 0", outValid);
    end
    checks++;
    if (outBits !== '0) begin
      failures++; $display("FAIL reset_bits: got %h expected 0", outBits);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (ovfCnt !== 8'd0 || ferrCnt !== 8'd0) begin
      failures++; $display("FAIL reset_cnt: got ovf=%h ferr=%h expected 0/0", ovfCnt, ferrCnt);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_latency_order();
    logic [NL-1:0] d;
    beat_t         got[$];
    beat_t         b;
    for (int k = 1; k <= 4; k++) begin
      b = all_lanes(8'(k));
      for (int i = 0; i < 8; i++) begin
        for (int l = 0; l < NL; l++) d[l] = b[l][7-i];
        cycle(1'b1, d, 1'b1, 1'b0);
        if (k == 1 && (i == 6 || i == 7)) begin
          checks++;
          if (outValid !== (i == 7)) begin
            failures++;
            $display("FAIL latency_bit%0d: got valid=%b expected %b", i, outValid, i == 7);
          end
        end
        if (outValid) got.push_back(outBits);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL order_count: got %0d beats expected 4", got.size());
    end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++;
      if (got[k] !== all_lanes(8'(k + 1))) begin
        failures++;
        $display("FAIL order_beat%0d: got %h expected %h", k, got[k], all_lanes(8'(k + 1)));
      end
    end
  endtask

  task automatic test_lane_pattern();
    beat_t b;
    for (int l = 0; l < NL; l++) b[l] = 8'hA0 + 8'(l);
    send_beat(b, 1'b1);
    checks++;
    if (outValid !== 1'b1 || outBits !== b) begin
      failures++; $display("FAIL lane_pattern: got v=%b %h expected 1 %h", outValid, outBits, b);
    end
    for (int l = 0; l < NL; l++) begin
      checks++;
      if (outBits[8*l +: 8] !== 8'hA0 + 8'(l)) begin
        failures++;
        $display("FAIL lane_byte%0d: got %h expected %h", l, outBits[8*l +: 8], 8'hA0 + 8'(l));
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    beat_t b1, b2, b3;
    b1 = rand_beat();
    b2 = rand_beat();
    b3 = rand_beat();
    cycle(1'b0, '0, 1'b0, 1'b1);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    send_beat(b3, 1'b0);
    checks++;
    if (ovfCnt !== (CntEn ? 8'd1 : 8'd0)) begin
      failures++; $display("FAIL ovf_count: got %h expected %h", ovfCnt, CntEn ? 8'd1 : 8'd0);
    end
    checks++;
    if (outValid !== 1'b1 || outBits !== b1) begin
      failures++; $display("FAIL ovf_head1: got v=%b %h expected 1 %h", outValid, outBits, b1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b1 || outBits !== b2) begin
      failures++; $display("FAIL ovf_head2: got v=%b %h expected 1 %h", outValid, outBits, b2);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b0) begin
      failures++; $display("FAIL ovf_beat3_absent: got valid=%b expected 0", outValid);
    end
  endtask

  task automatic test_full_and_deq();
    beat_t         b1, b2, b3;
    logic [NL-1:0] d;
    b1 = rand_beat();
    b2 = rand_beat();
    b3 = rand_beat();
    cycle(1'b0, '0, 1'b0, 1'b1);
    send_beat(b1, 1'b0);
    send_beat(b2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < NL; l++) d[l] = b3[l][7-i];
      cycle(1'b1, d, (i == 7), 1'b0);
    end
    checks++;
    if (ovfCnt !== 8'd0) begin
      failures++; $display("FAIL full_deq_ovf: got %h expected 00", ovfCnt);
    end
    checks++;
    if (outValid !== 1'b1 || outBits !== b2) begin
      failures++; $display("FAIL full_deq_head: got v=%b %h expected 1 %h", outValid, outBits, b2);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b1 || outBits !== b3) begin
      failures++; $display("FAIL full_deq_b3: got v=%b %h expected 1 %h", outValid, outBits, b3);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b0) begin
      failures++; $display("FAIL full_deq_drain: got valid=%b expected 0", outValid);
    end
  endtask

  task automatic test_frame_err();
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, NL'($urandom), 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL ferr_busy: got %b expected 1", busy);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b0 || ferrCnt !== (CntEn ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL ferr_count: got busy=%b cnt=%h expected 0 %h", busy, ferrCnt,
               CntEn ? 8'd1 : 8'd0);
    end
    send_beat(all_lanes(8'h5A), 1'b1);
    checks++;
    if (outValid !== 1'b1 || outBits !== all_lanes(8'h5A)) begin
      failures++; $display("FAIL ferr_beat: got v=%b %h expected 1 5a..", outValid, outBits);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b0) begin
      failures++; $display("FAIL ferr_single: got valid=%b expected 0", outValid);
    end
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 5; i++) cycle(1'b1, NL'($urandom), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (ferrCnt !== (CntEn ? 8'hFF : 8'h00)) begin
      failures++; $display("FAIL ferr_saturate: got %h expected %h", ferrCnt, CntEn ? 8'hFF : 8'h00);
    end
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (ferrCnt !== 8'h00 || ovfCnt !== 8'h00) begin
      failures++; $display("FAIL cnt_clear: got ferr=%h ovf=%h expected 00/00", ferrCnt, ovfCnt);
    end
  endtask

  task automatic test_reset_mid();
    beat_t b1, b2, b3;
    b1 = rand_beat();
    b2 = rand_beat();
    b3 = rand_beat();
    cycle(1'b0, '0, 1'b0, 1'b1);
    send_beat(b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, NL'($urandom), 1'b0, 1'b0);
    serValid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || outBits !== '0) begin
      failures++;
      $display("FAIL rst_mid_state: got v=%b busy=%b bits=%h expected 0 0 0", outValid, busy,
               outBits);
    end
    checks++;
    if (ovfCnt !== 8'd0 || ferrCnt !== 8'd0) begin
      failures++; $display("FAIL rst_mid_cnt: got ovf=%h ferr=%h expected 0/0", ovfCnt, ferrCnt);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_beat(b3, 1'b1);
    checks++;
    if (outValid !== 1'b1 || outBits !== b3) begin
      failures++; $display("FAIL rst_mid_next: got v=%b %h expected 1 %h", outValid, outBits, b3);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    if (b2 == b1) serData = '0;
  endtask

  task automatic test_random();
    logic v, rdy, clr;
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom_range(0, 11) != 0);
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 59) == 0);
      cycle(v, NL'($urandom), rdy, clr);
      checks++;
      if (outValid !== (mQ.size() > 0)) begin
        failures++; $display("FAIL rand_valid c%0d: got %b expected %b", c, outValid, mQ.size() > 0);
      end
      if (mQ.size() > 0) begin
        checks++;
        if (outBits !== mQ[0]) begin
          failures++; $display("FAIL rand_bits c%0d: got %h expected %h", c, outBits, mQ[0]);
        end
      end
      checks++;
      if (busy !== (mCount != 0)) begin
        failures++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, mCount != 0);
      end
      checks++;
      if (ovfCnt !== 8'(mOvf) || ferrCnt !== 8'(mFerr)) begin
        failures++;
        $display("FAIL rand_cnt c%0d: got ovf=%h ferr=%h expected %h %h", c, ovfCnt, ferrCnt,
                 8'(mOvf), 8'(mFerr));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency_order();
    test_lane_pattern();
    test_overflow();
    test_full_and_deq();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_lane_deser.md
# phy_lane_deser

Receive-side lane deserializer for the PHY test datapath: samples `NUM_LANES` single-bit serial lanes, framed by a shared valid lane, and rebuilds one byte per lane every `LANE_BITS` sampled bits. Completed beats go into a small FIFO and are presented on a ready/valid user interface matching the `rxData` bundle that the transmit serializer consumes. It sits between the lane sampling logic and the user-side consumer, so the two ends of the test loop can be compared beat-for-beat.

## Interface
- `NUM_LANES`, 16, number of data lanes; one output byte per lane.
- `LANE_BITS`, 8, serial bits per lane per beat (fixed at 8 for this revision).
- `FIFO_DEPTH`, 2, output buffer entries; power of two, ≥2.
- `clock`  input  1  single clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `io_ser_data`  input  NUM_LANES  serial bit per lane, sampled when `io_ser_valid`=1.
- `io_ser_valid`  input  1  valid lane; high for every bit of a beat.
- `io_out_valid`  output  1  FIFO head holds a beat.
- `io_out_ready`  input  1  consumer accepts head.
- `io_out_bits`  output  NUM_LANES*8  lane l byte at [8l+7:8l].
- `io_busy`  output  1  beat partially assembled (bit count ≠ 0).
- `io_cnt_clear`  input  1  synchronous clear of both error counters.
- `io_overflow_cnt`  output  8  beats dropped on full FIFO, saturating.
- `io_frame_err_cnt`  output  8  partial beats discarded, saturating.

## Operation
- FSM states: IDLE (bit count 0), SHIFT (1..7 bits held).
- IDLE: on `io_ser_valid`=1 sample bit 0 → SHIFT, count=1.
- SHIFT: `io_ser_valid`=1 → sample next bit, count+1; on the 8th bit the beat completes, count wraps to 0 → IDLE.
- SHIFT with `io_ser_valid`=0 → discard partial bits, count=0, `io_frame_err_cnt`+1 → IDLE.
- Bit order MSB-first: i-th sampled bit (i=0..7) of lane l → `io_out_bits[8l+7-i]`.
- Beat completion writes the assembled word (7 held bits + current bit) into the FIFO at the same edge.
- FIFO full on completion: if `io_out_ready`=1 in that cycle, dequeue and enqueue both happen (no drop); otherwise beat dropped, `io_overflow_cnt`+1.
- Counters saturate at 8'hFF; `io_cnt_clear`=1 zeroes both and wins over a same-cycle increment.
- Dequeue when `io_out_valid && io_out_ready`; `io_out_bits` holds steady while valid and not ready.

## Timing
- Reset values: `io_out_valid`=0, `io_out_bits`=0, `io_busy`=0, both counters 0, FIFO empty, FSM IDLE, count 0.
- Reset asserted mid-beat or with data in the FIFO: everything returns immediately to the reset values; partial and buffered beats are lost and the error counters do not increment.
- Latency: the first bit is sampled at edge t0. With 8 consecutive valid cycles, `io_out_valid` rises in the cycle after edge t0+7 (8 cycles).
- Throughput: one beat per 8 cycles with `io_ser_valid` held high continuously. Back-to-back beats need no idle gap.
- `io_out_valid` depends only on registers. There is no combinational path from `io_out_ready` to `io_out_valid` or `io_out_bits`.

## Configuration
- `PHY_LANE_DESER_ERR_CNT_EN` defined: both counters and `io_cnt_clear` are functional as specified.
- Not defined: both counters are tied to 0 and `io_cnt_clear` is ignored. Dropping and discarding still happen exactly as specified; only the counting is removed.

## Structure
- Shared package `phy_test_pkg` holds:
  - `NUM_LANES_DEF`=16 and `LANE_BITS_DEF`=8.
  - `deser_state_e` {IDLE, SHIFT}.
  - The beat word typedef: a packed array of `NUM_LANES` bytes.
- Sub-module `phy_beat_fifo`: parameterized sync FIFO (width, depth) with a full-and-dequeue-same-cycle enqueue allowed. It provides `full`, `empty`, `enq`, `deq`.
- The deserializer contains the FSM, per-lane shift registers, and the counters.

## Test plan
- Reset release, then 4 beats of 8 valid bits each; lane patterns encode bytes 0x01..0x04 on all lanes; `io_out_ready`=1 → 4 outputs, every byte 0x01, 0x02, 0x03, 0x04 in order, first valid 8 cycles after first bit.
- Lane l sends 8'hA0+l MSB-first → `io_out_bits[8l+7:8l]`=8'hA0+l for l=0..15.
- `io_out_ready`=0, 3 beats sent → first 2 held (FIFO_DEPTH=2), `io_overflow_cnt`=1. Then ready=1 → beats 1 and 2 delivered, beat 3 absent.
- FIFO full and the 3rd beat completing in the same cycle as ready=1 → no drop, `io_overflow_cnt`=0.
- `io_ser_valid` dropped after 5 bits, then a full beat 0x5A → `io_frame_err_cnt`=1, a single output 0x5A. Repeat 300 times → counter stays at 8'hFF. `io_cnt_clear` pulse → 0.
- `reset` asserted after 4 bits with one beat buffered → `io_out_valid`=0, `io_busy`=0, counters unchanged at 0. The next full beat is delivered correctly.
